// File: rtl/peripheral_bus_pkg.sv
// Shared definitions for the peripheral bus: register map, UART state
// encoding and the default bit period.
package peripheral_bus_pkg;

    // 50 MHz / 9600 baud
    localparam int unsigned CLKS_PER_BIT_DEF = 5208;

    localparam logic [31:0] ADDR_TH       = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL       = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON     = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED      = 32'h4000_000C;
    localparam logic [31:0] ADDR_SWITCH   = 32'h4000_0010;
    localparam logic [31:0] ADDR_DIGI     = 32'h4000_0014;
    localparam logic [31:0] ADDR_UART_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_UART_CON = 32'h4000_001C;

    localparam logic [1:0] UART_IDLE  = 2'd0;
    localparam logic [1:0] UART_START = 2'd1;
    localparam logic [1:0] UART_DATA  = 2'd2;
    localparam logic [1:0] UART_STOP  = 2'd3;

    // Word-aligned match; the byte offset bits are ignored.
    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] reg_addr);
        return addr[31:2] == reg_addr[31:2];
    endfunction

endpackage

// File: rtl/peripheral_bus_if.sv
// Core MEM-stage data bus as seen by the peripheral block.
//   iMemAddr/iMemRead/iMemWrite/iMemWriteData : core -> peripherals
//   oMemReadData                              : peripherals -> core (combinational)
interface peripheral_bus_if;
    logic [31:0] iMemAddr;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iMemWriteData;
    logic [31:0] oMemReadData;

    modport master (
        output iMemAddr, iMemRead, iMemWrite, iMemWriteData,
        input  oMemReadData
    );

    modport slave (
        input  iMemAddr, iMemRead, iMemWrite, iMemWriteData,
        output oMemReadData
    );
endinterface

// File: rtl/peripheral_bus_uart_tx.sv
// 8N1 UART transmitter, LSB first.
//   clk, reset (sync, active low), start (accepted only when idle),
//   data[7:0] (latched on start), busy, tx (idle high).
//
//   state      | meaning
//   UART_IDLE  | line high, waiting for start
//   UART_START | start bit, line low
//   UART_DATA  | shifting out 8 data bits
//   UART_STOP  | stop bit, line high
module uart_tx
    import peripheral_bus_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    // Baud timer is a down-counter; a bit ends on the cycle it reads zero.
    localparam logic [15:0] BAUD_LOAD = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            UART_IDLE: begin
                if (start) begin
                    state_d = UART_START;
                    baud_d  = BAUD_LOAD;
                    bit_d   = 3'd0;
                    shift_d = data;
                end
            end
            UART_START: begin
                if (baud_q == 16'd0) begin
                    state_d = UART_DATA;
                    baud_d  = BAUD_LOAD;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            UART_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d  = BAUD_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            UART_STOP: begin
                if (baud_q == 16'd0) begin
                    state_d = UART_IDLE;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= UART_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign busy = (state_q != UART_IDLE);
    assign tx   = (state_q == UART_START) ? 1'b0 :
                  (state_q == UART_DATA)  ? shift_q[0] : 1'b1;

endmodule

// File: rtl/peripheral_bus.sv
// Memory-mapped peripherals: 32-bit reload timer with interrupt, LED,
// switch and seven-segment registers, and a UART transmitter.
//   clk, reset (sync, active low)
//   bus        : core data bus (slave side), combinational read data
//   oInterrupt : timer interrupt request
//   iSwitch    : board switches; oLed, oDigi : registered outputs
//   oUartTx    : serial output, idle high
module peripheral_bus
    import peripheral_bus_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    peripheral_bus_if.slave        bus,
    output logic                   oInterrupt,
    input  logic [7:0]             iSwitch,
    output logic [7:0]             oLed,
    output logic [11:0]            oDigi,
    output logic                   oUartTx
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic        uart_busy;

    logic wr_th, wr_tl, wr_tcon, wr_led, wr_digi, wr_txd;

    assign wr_th   = bus.iMemWrite & addr_hit(bus.iMemAddr, ADDR_TH);
    assign wr_tl   = bus.iMemWrite & addr_hit(bus.iMemAddr, ADDR_TL);
    assign wr_tcon = bus.iMemWrite & addr_hit(bus.iMemAddr, ADDR_TCON);
    assign wr_led  = bus.iMemWrite & addr_hit(bus.iMemAddr, ADDR_LED);
    assign wr_digi = bus.iMemWrite & addr_hit(bus.iMemAddr, ADDR_DIGI);
    assign wr_txd  = bus.iMemWrite & addr_hit(bus.iMemAddr, ADDR_UART_TXD);

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        digi_d = digi_q;

        if (wr_th)   th_d   = bus.iMemWriteData;
        if (wr_led)  led_d  = bus.iMemWriteData[7:0];
        if (wr_digi) digi_d = bus.iMemWriteData[11:0];

        // A bus write to TL or TCON suppresses the timer step entirely,
        // so software never races an overflow it is trying to clear.
        if (wr_tl || wr_tcon) begin
            if (wr_tl)   tl_d   = bus.iMemWriteData;
            if (wr_tcon) tcon_d = bus.iMemWriteData[2:0];
        end else if (tcon_q[0]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[1]) tcon_d[2] = 1'b1;
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            th_q   <= 32'd0;
            tl_q   <= 32'd0;
            tcon_q <= 3'd0;
            led_q  <= 8'd0;
            digi_q <= 12'd0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            digi_q <= digi_d;
        end
    end

    always_comb begin
        bus.oMemReadData = 32'd0;
        if (bus.iMemRead) begin
            case (bus.iMemAddr[31:2])
                ADDR_TH[31:2]:       bus.oMemReadData = th_q;
                ADDR_TL[31:2]:       bus.oMemReadData = tl_q;
                ADDR_TCON[31:2]:     bus.oMemReadData = {29'd0, tcon_q};
                ADDR_LED[31:2]:      bus.oMemReadData = {24'd0, led_q};
                ADDR_SWITCH[31:2]:   bus.oMemReadData = {24'd0, iSwitch};
                ADDR_DIGI[31:2]:     bus.oMemReadData = {20'd0, digi_q};
                ADDR_UART_CON[31:2]: bus.oMemReadData = {31'd0, uart_busy};
                default:             bus.oMemReadData = 32'd0;
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .start (wr_txd),
        .data  (bus.iMemWriteData[7:0]),
        .busy  (uart_busy),
        .tx    (oUartTx)
    );

    assign oInterrupt = tcon_q[1] & tcon_q[2];
    assign oLed       = led_q;
    assign oDigi      = digi_q;

endmodule

// File: tb/tb_peripheral_bus.sv
module tb_peripheral_bus;

    localparam int CPB = 4;
    localparam int FRAME_CYCLES = 10 * CPB;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_SW   = 32'h4000_0010;
    localparam logic [31:0] A_DIGI = 32'h4000_0014;
    localparam logic [31:0] A_TXD  = 32'h4000_0018;
    localparam logic [31:0] A_CON  = 32'h4000_001C;

    logic        clk;
    logic        reset;
    logic        oInterrupt;
    logic [7:0]  iSwitch;
    logic [7:0]  oLed;
    logic [11:0] oDigi;
    logic        oUartTx;

    peripheral_bus_if bus_if ();

    peripheral_bus #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .oInterrupt (oInterrupt),
        .iSwitch    (iSwitch),
        .oLed       (oLed),
        .oDigi      (oDigi),
        .oUartTx    (oUartTx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_th, m_tl;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_digi;
    int          m_left;
    logic [9:0]  m_frame;

    logic [31:0] obs_rd;
    logic        obs_int;
    logic        obs_tx;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] addr, input logic rd);
        logic [31:0] word;
        word = {addr[31:2], 2'b00};
        if (!rd) return 32'd0;
        case (word)
            A_TH:    return m_th;
            A_TL:    return m_tl;
            A_TCON:  return {29'd0, m_tcon};
            A_LED:   return {24'd0, m_led};
            A_SW:    return {24'd0, iSwitch};
            A_DIGI:  return {20'd0, m_digi};
            A_CON:   return (m_left > 0) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_tx();
        if (m_left == 0) return 1'b1;
        return m_frame[(FRAME_CYCLES - m_left) / CPB];
    endfunction

    function automatic void model_step(input logic rst_n, input logic wr,
                                       input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] word;
        logic [31:0] th_next;
        word = {addr[31:2], 2'b00};
        if (!rst_n) begin
            m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_left = 0;
            return;
        end
        th_next = (wr && word == A_TH) ? wd : m_th;
        if (wr && (word == A_TL || word == A_TCON)) begin
            if (word == A_TL)   m_tl = wd;
            if (word == A_TCON) m_tcon = wd[2:0];
        end else if (m_tcon[0]) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                m_tl = m_th;
                if (m_tcon[1]) m_tcon[2] = 1'b1;
            end else begin
                m_tl = m_tl + 1;
            end
        end
        m_th = th_next;
        if (wr && word == A_LED)  m_led = wd[7:0];
        if (wr && word == A_DIGI) m_digi = wd[11:0];
        if (m_left > 0) begin
            m_left--;
        end else if (wr && word == A_TXD) begin
            m_frame = {1'b1, wd[7:0], 1'b0};
            m_left  = FRAME_CYCLES;
        end
    endfunction

    // One bus cycle: drive, check combinational outputs, clock, check registered outputs.
    task automatic cycle(input logic rst_n, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd);
        reset                = rst_n;
        bus_if.iMemRead      = rd;
        bus_if.iMemWrite     = wr;
        bus_if.iMemAddr      = addr;
        bus_if.iMemWriteData = wd;
        #2;
        obs_rd  = bus_if.oMemReadData;
        obs_int = oInterrupt;
        check_val("rdata", obs_rd, exp_read(addr, rd));
        check_val("irq_pre", {31'd0, obs_int}, {31'd0, m_tcon[1] & m_tcon[2]});
        @(posedge clk);
        model_step(rst_n, wr, addr, wd);
        #1;
        obs_tx = oUartTx;
        check_val("led", {24'd0, oLed}, {24'd0, m_led});
        check_val("digi", {20'd0, oDigi}, {20'd0, m_digi});
        check_val("uart_tx", {31'd0, obs_tx}, {31'd0, exp_tx()});
        check_val("irq_post", {31'd0, oInterrupt}, {31'd0, m_tcon[1] & m_tcon[2]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [9:0]  seq;
        logic [39:0] got_bits, exp_bits;
        logic [31:0] addr, wd;
        int          idx;

        reset = 1'b0; iSwitch = 8'h00;
        bus_if.iMemRead = 1'b0; bus_if.iMemWrite = 1'b0;
        bus_if.iMemAddr = 32'd0; bus_if.iMemWriteData = 32'd0;
        m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_left = 0; m_frame = '1;
        @(posedge clk); @(posedge clk); #1;

        // reset state
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check_val("rst_tx", {31'd0, obs_tx}, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, A_TL, 32'd0);
        check_val("rst_tl", obs_rd, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, A_TCON, 32'd0);
        check_val("rst_tcon", obs_rd, 32'd0);

        // timer overflow with reload and interrupt
        cycle(1'b1, 1'b0, 1'b1, A_TH, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 1'b1, A_TL, 32'hFFFF_FFFE);
        cycle(1'b1, 1'b0, 1'b1, A_TCON, 32'd3);
        cycle(1'b1, 1'b1, 1'b0, A_TL, 32'd0);
        check_val("tl_fffe", obs_rd, 32'hFFFF_FFFE);
        cycle(1'b1, 1'b1, 1'b0, A_TL, 32'd0);
        check_val("tl_ffff", obs_rd, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b1, 1'b0, A_TCON, 32'd0);
        check_val("tcon_after_reload", obs_rd, 32'd7);
        check_val("irq_after_reload", {31'd0, obs_int}, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, A_TL, 32'd0);
        check_val("tl_reloaded_plus1", obs_rd, 32'hFFFF_FFFD);
        cycle(1'b1, 1'b0, 1'b1, A_TCON, 32'd3);
        cycle(1'b1, 1'b1, 1'b0, A_TCON, 32'd0);
        check_val("tcon_cleared", obs_rd, 32'd3);
        check_val("irq_cleared", {31'd0, obs_int}, 32'd0);

        // TL write colliding with overflow
        cycle(1'b1, 1'b0, 1'b1, A_TL, 32'hFFFF_FFFE);
        idle(1);
        cycle(1'b1, 1'b0, 1'b1, A_TL, 32'h10);
        cycle(1'b1, 1'b1, 1'b0, A_TL, 32'd0);
        check_val("tl_write_wins", obs_rd, 32'h10);
        cycle(1'b1, 1'b1, 1'b0, A_TCON, 32'd0);
        check_val("tcon_no_status", obs_rd, 32'd3);
        cycle(1'b1, 1'b0, 1'b1, A_TCON, 32'd0);

        // GPIO and decode
        iSwitch = 8'h5A;
        cycle(1'b1, 1'b1, 1'b0, A_SW, 32'd0);
        check_val("switch", obs_rd, 32'h0000_005A);
        cycle(1'b1, 1'b1, 1'b0, 32'h4000_0020, 32'd0);
        check_val("unmapped", obs_rd, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, A_SW, 32'd0);
        check_val("no_read", obs_rd, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, A_LED, 32'h1FF);
        check_val("led_trunc", {24'd0, oLed}, 32'hFF);
        cycle(1'b1, 1'b0, 1'b1, A_DIGI, 32'hFFFF_F123);
        check_val("digi_trunc", {20'd0, oDigi}, 32'h123);

        // UART frame 0xA5 with a dropped mid-frame write
        seq = 10'b1101001010;
        for (int k = 0; k < 40; k++) exp_bits[k] = seq[k / CPB];
        cycle(1'b1, 1'b0, 1'b1, A_TXD, 32'hA5);
        got_bits[0] = obs_tx;
        for (int k = 1; k < 40; k++) begin
            if (k == 10) cycle(1'b1, 1'b1, 1'b1, A_TXD, 32'h3C);
            else         cycle(1'b1, 1'b1, 1'b0, A_CON, 32'd0);
            if (k != 10) check_val("uart_busy", obs_rd, 32'd1);
            got_bits[k] = obs_tx;
        end
        check_val("uart_bits_lo", got_bits[31:0], exp_bits[31:0]);
        check_val("uart_bits_hi", {24'd0, got_bits[39:32]}, {24'd0, exp_bits[39:32]});
        cycle(1'b1, 1'b1, 1'b0, A_CON, 32'd0);
        check_val("uart_busy_last", obs_rd, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, A_CON, 32'd0);
        check_val("uart_idle", obs_rd, 32'd0);
        // back-to-back frame start from idle
        cycle(1'b1, 1'b0, 1'b1, A_TXD, 32'h81);
        check_val("uart_restart", {31'd0, obs_tx}, 32'd0);

        // reset mid-frame
        idle(FRAME_CYCLES + 2);
        cycle(1'b1, 1'b0, 1'b1, A_TXD, 32'h3C);
        idle(CPB + 5);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check_val("abort_tx", {31'd0, obs_tx}, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, A_CON, 32'd0);
        check_val("abort_busy", obs_rd, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, A_LED, 32'd0);
        check_val("abort_led", obs_rd, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, A_DIGI, 32'd0);
        check_val("abort_digi", obs_rd, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, A_TH, 32'd0);
        check_val("abort_th", obs_rd, 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            iSwitch = 8'($urandom);
            idx = int'($urandom_range(0, 9));
            if (idx == 9) addr = $urandom;
            else          addr = 32'h4000_0000 + 32'(idx * 4) + 32'($urandom_range(0, 3));
            wd = $urandom;
            if (idx == 1 && $urandom_range(0, 1) == 1)
                wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if (idx == 2 && $urandom_range(0, 1) == 1)
                wd = wd | 32'h1;
            cycle(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), addr, wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/peripheral_bus.md
PERIPHERAL_BUS -- requirements
Module: peripheral_bus

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 5208, clock cycles per UART bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 iMemAddr  input  32  byte address from the core MEM stage.
REQ-005 iMemRead  input  1  read strobe from the core.
REQ-006 iMemWrite  input  1  write strobe from the core.
REQ-007 iMemWriteData  input  32  store data from the core.
REQ-008 oMemReadData  output  32  combinational read data back to the core.
REQ-009 oInterrupt  output  1  timer interrupt request to the core.
REQ-010 iSwitch  input  8  board switches.
REQ-011 oLed  output  8  board LEDs.
REQ-012 oDigi  output  12  seven-segment drive word.
REQ-013 oUartTx  output  1  UART serial output, idle high.

Function
REQ-014 Register map (word aligned; iMemAddr[1:0] ignored):
- 0x40000000 TH, RW 32
- 0x40000004 TL, RW 32
- 0x40000008 TCON, RW [2:0]: bit0 enable, bit1 irq enable, bit2 irq status
- 0x4000000C LED, RW [7:0]
- 0x40000010 SWITCH, RO [7:0]
- 0x40000014 DIGI, RW [11:0]
- 0x40000018 UART_TXD, WO [7:0]
- 0x4000001C UART_CON, RO bit0 tx busy
REQ-015 Reads are combinational, zero latency: oMemReadData = iMemRead ? decoded register (zero-extended) : 0; unmapped addresses and WO registers read 0.
REQ-016 Writes take effect at the rising edge where iMemWrite=1; writes to unmapped, RO or unimplemented bits are ignored.
REQ-017 Timer: when TCON[0]=1, TL increments by 1 each cycle; when TL=0xFFFFFFFF it reloads TH instead, and if TCON[1]=1 sets TCON[2] in the same edge.
REQ-018 oInterrupt = TCON[1] & TCON[2], combinational; software clears it by writing TCON.
REQ-019 Same-cycle bus write and timer update to TL or TCON: the bus write wins entirely (no increment, no status set that cycle).
REQ-020 TH change takes effect only at the next reload; TL is never cleared except by reset or a write.
REQ-021 oLed = LED register, oDigi = DIGI register, directly registered.
REQ-022 UART TX state machine, 8N1, LSB first: IDLE -> START (1 bit low) -> DATA (8 bits) -> STOP (1 bit high) -> IDLE; each bit is held exactly CLKS_PER_BIT cycles.
REQ-023 A write to UART_TXD in IDLE latches data[7:0] and enters START at that edge, so oUartTx falls on the next cycle and busy=1 from the next cycle.
REQ-024 A write to UART_TXD while busy is dropped without effect.
REQ-025 busy=1 in START, DATA and STOP; busy=0 from the cycle after the STOP bit completes, so the next frame can start back-to-back.

Reset
REQ-026 When reset=0 at a rising edge: TH, TL, TCON, LED, DIGI = 0; UART goes to IDLE with bit counter and baud counter 0; oUartTx=1; oInterrupt=0.
REQ-027 Reset asserted mid-frame aborts the frame immediately; oUartTx=1 from the following cycle.

Structure
REQ-028 Shared package holds the register address constants, the UART state encoding and the CLKS_PER_BIT default.
REQ-029 UART transmitter is one sub-module, uart_tx (ports: clk, reset, start, data[7:0], busy, tx); decode, timer and GPIO registers stay in peripheral_bus.

Verification
REQ-030 Write TH=0xFFFFFFFC, TL=0xFFFFFFFE, TCON=3 -> TL reaches 0xFFFFFFFF then reloads to 0xFFFFFFFC, TCON reads 7 and oInterrupt=1 on the reload edge; write TCON=3 -> oInterrupt=0 next cycle.
REQ-031 Timer running with a TL write of 0x10 in the same cycle as the overflow -> TL=0x10 and TCON[2] stays 0.
REQ-032 CLKS_PER_BIT=4, write UART_TXD=0xA5 -> oUartTx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; UART_CON reads 1 throughout and 0 after 40 cycles; a second write mid-frame changes nothing.
REQ-033 iSwitch=0x5A, read 0x40000010 -> 0x0000005A; read 0x40000020 -> 0; iMemRead=0 -> 0; write LED=0x1FF -> oLed=0xFF.
REQ-034 Reset pulsed during the DATA bits of a frame -> oUartTx=1 and busy=0 next cycle; all registers read 0.
